axis_rd_checker: RTL

AXIS_RD_CHECKER -- requirements
Module: axis_rd_checker

---
 rtl/axis_chk_pkg.sv | 21 ++
 rtl/axis_lfsr16.sv | 41 ++++
 rtl/axis_rd_checker.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/axis_chk_pkg.sv
// Shared types and constants for the AXIS read-data checker: FSM states,
// LFSR tap mask, default seed and the LFSR step function.
package axis_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          LFSR_W       = 16;
  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axis_lfsr16.sv
// 16-bit Fibonacci LFSR producing the expected data pattern; load restarts
// the sequence at SEED, enable advances it by one step.
module axis_lfsr16
  import axis_chk_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_en,
  output logic [15:0] o_value
);

  logic [15:0] r_value;
  logic [15:0] w_next;

  // Next value: load beats advance so a restart never skips the seed word.
  always_comb begin
    w_next = r_value;
    if (i_load) begin
      w_next = SEED;
    end else if (i_en) begin
      w_next = lfsr_step(r_value);
    end else begin
      w_next = r_value;
    end
  end

  // State register with synchronous reset to the seed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_value <= SEED;
    end else begin
      r_value <= w_next;
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/axis_rd_checker.sv
// Checks a DDR3 read stream against an LFSR pattern: paces tready, counts
// beats and mismatches, and captures the first failing beat.
module axis_rd_checker
  import axis_chk_pkg::*;
#(
  parameter int          DATA_W = 16,
  parameter logic [15:0] SEED   = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_axis_tvaild,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic              s_axis_tready,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       cfg_len,
  input  logic [3:0]        cfg_stall,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       word_cnt,
  output logic [15:0]       err_cnt,
  output logic [15:0]       fail_idx,
  output logic [15:0]       fail_exp,
  output logic [15:0]       fail_got
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_tready;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [15:0] r_word_cnt;
  logic [15:0] r_err_cnt;
  logic [15:0] r_fail_idx;
  logic [15:0] r_fail_exp;
  logic [15:0] r_fail_got;
  logic [15:0] r_len;
  logic [3:0]  r_stall;
  logic [3:0]  r_stall_cnt;

  logic        w_beat;
  logic        w_start_ok;
  logic        w_mismatch;
  logic        w_last;
  logic [15:0] w_expected;
  logic [15:0] w_word_nxt;
  logic [15:0] w_err_nxt;

  axis_lfsr16 #(.SEED(SEED)) u_lfsr (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_start_ok),
    .i_en    (w_beat),
    .o_value (w_expected)
  );

  assign w_beat     = s_axis_tvaild & r_tready;
  // Abort beats a simultaneous start; starts while a run is active are dropped.
  assign w_start_ok = start & ~abort & ((r_state == IDLE) | (r_state == DONE));
  assign w_mismatch = w_beat & (s_axis_tdata != w_expected);
  assign w_last     = w_beat & (({1'b0, r_word_cnt} + 17'd1) == {1'b0, r_len});

  // Beat and error counters, both saturating.
  always_comb begin
    w_word_nxt = r_word_cnt;
    w_err_nxt  = r_err_cnt;
    if (w_start_ok) begin
      w_word_nxt = 16'h0000;
      w_err_nxt  = 16'h0000;
    end else begin
      if (w_beat && (r_word_cnt != 16'hFFFF)) begin
        w_word_nxt = r_word_cnt + 16'd1;
      end else begin
        w_word_nxt = r_word_cnt;
      end
      if (w_mismatch && (r_err_cnt != 16'hFFFF)) begin
        w_err_nxt = r_err_cnt + 16'd1;
      end else begin
        w_err_nxt = r_err_cnt;
      end
    end
  end

  // FSM next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            w_state_nxt = (cfg_len == 16'd0) ? DONE : RUN;
          end else begin
            w_state_nxt = r_state;
          end
        end
        RUN: begin
          if (w_last) begin
            w_state_nxt = DONE;
          end else if (w_beat && (r_stall != 4'd0)) begin
            w_state_nxt = STALL;
          end else begin
            w_state_nxt = RUN;
          end
        end
        STALL: begin
          if (r_stall_cnt <= 4'd1) begin
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = STALL;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Registered FSM, status outputs, counters and first-failure capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tready    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_word_cnt  <= 16'h0000;
      r_err_cnt   <= 16'h0000;
      r_fail_idx  <= 16'h0000;
      r_fail_exp  <= 16'h0000;
      r_fail_got  <= 16'h0000;
      r_len       <= 16'h0000;
      r_stall     <= 4'd0;
      r_stall_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_tready   <= (w_state_nxt == RUN);
      r_busy     <= (w_state_nxt == RUN) || (w_state_nxt == STALL);
      r_done     <= (w_state_nxt == DONE);
      r_pass     <= (w_state_nxt == DONE) && (w_err_nxt == 16'h0000);
      r_word_cnt <= w_word_nxt;
      r_err_cnt  <= w_err_nxt;

      if (w_start_ok) begin
        r_len      <= cfg_len;
        r_stall    <= cfg_stall;
        r_fail_idx <= 16'h0000;
        r_fail_exp <= 16'h0000;
        r_fail_got <= 16'h0000;
      end else if (w_mismatch && (r_err_cnt == 16'h0000)) begin
        r_fail_idx <= r_word_cnt;
        r_fail_exp <= w_expected;
        r_fail_got <= s_axis_tdata;
      end

      if ((r_state == RUN) && (w_state_nxt == STALL)) begin
        r_stall_cnt <= r_stall;
      end else if (r_state == STALL) begin
        r_stall_cnt <= r_stall_cnt - 4'd1;
      end
    end
  end

  assign s_axis_tready = r_tready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign word_cnt      = r_word_cnt;
  assign err_cnt       = r_err_cnt;
  assign fail_idx      = r_fail_idx;
  assign fail_exp      = r_fail_exp;
  assign fail_got      = r_fail_got;

endmodule
